instr_fetch_queue: RTL

// - Decoupling queue between instruction fetch and decode: buffers {PC, instruction} pairs from fetch and presents them in order to decode.
// - Absorbs decode stalls without stopping the fetch PC. On a control-flow redirect, `flush` discards every buffered wrong-path entry.
// - Sits directly downstream of the fetch stage (PC register + instruction memory) and upstream of decode/register read.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fq_storage.sv | 32 +++
 rtl/instr_fetch_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions.
//   XLEN          width of PC and instruction words
//   NOP_INSTR     canonical NOP (addi x0, x0, 0), presented when nothing valid is queued
//   fetch_entry_t {pc, instr} pair as handed from fetch to decode
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Register array backing the instruction fetch queue.
//   clk      rising-edge clock
//   wr_en    write wr_data into entry wr_addr at the clock edge
//   wr_addr  write index
//   wr_data  write data
//   rd_addr  read index
//   rd_data  entry at rd_addr, combinational read
// The array has no reset; occupancy tracking in the parent decides what is valid.
module fq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Buffers {pc, instr} pairs and hands
// them to decode in order; flush drops all wrong-path entries on a redirect.
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     fetch-side handshake; in_pc/in_instr are the offered entry
//   out_valid/out_ready   decode-side handshake; out_pc/out_instr are the head entry
//   flush                 synchronous clear, overrides any push/pop in the same cycle
//   count                 current occupancy (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap by natural overflow.
module instr_fetch_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    import riscv_pkg::NOP_INSTR;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_rd_data;

    // Ready/valid come only from registered occupancy: no full pass-through, no fall-through.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN),
        .AW    (PW)
    ) u_storage (
        .clk     (clk),
        .wr_en   (w_push & ~flush),
        .wr_addr (r_wr_ptr),
        .wr_data ({in_pc, in_instr}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Mask the head when empty so decode never sees stale array contents.
    assign out_pc    = out_valid ? w_rd_data[2*XLEN-1:XLEN] : '0;
    assign out_instr = out_valid ? w_rd_data[XLEN-1:0] : XLEN'(NOP_INSTR);
    assign count     = r_count;

endmodule
